psum_accumulator: RTL and testbench

Parametrised partial-sum accumulation buffer sitting between the corelet output FIFO and the SFP/readout path of `core`. It absorbs one `col`-wide psum row per cycle, overwrites on kernel tap 0 and saturating-accumulates on taps 1..N-1 over `npos` output positions. After the last tap it drains the accumulated rows, with optional ReLU, through a valid/ready port. It replaces the fixed 8×36×9 psum SRAM arrangement with configurable depth, tap count and column count, and adds in-place read-modify-write accumulation.

---
 rtl/psum_accum_pkg.sv | 38 +++
 rtl/psum_lane_sat_add.sv | 32 +++
 rtl/psum_accumulator.sv | 182 ++++++++++++++++++
 tb/tb_psum_accumulator.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_accum_pkg.sv
// Shared types and arithmetic for the psum accumulation buffer.
package psum_accum_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FLUSH,
        DRAIN
    } state_t;

    // Widest lane the saturating adder supports; callers sign-extend into it.
    localparam int unsigned SAT_MAX_BW = 32;

    typedef logic signed [SAT_MAX_BW:0] sat_wide_t;

    // Two's-complement add clamped to the signed range of a bw-bit lane.
    function automatic logic signed [SAT_MAX_BW-1:0] sat_add(
        input logic signed [SAT_MAX_BW-1:0] a,
        input logic signed [SAT_MAX_BW-1:0] b,
        input int unsigned                  bw
    );
        sat_wide_t s;
        sat_wide_t hi;
        sat_wide_t lo;
        sat_wide_t one;
        one = sat_wide_t'(1);
        s   = sat_wide_t'(a) + sat_wide_t'(b);
        hi  = (one <<< (bw - 1)) - one;
        lo  = -(one <<< (bw - 1));
        if (s > hi) begin
            s = hi;
        end else if (s < lo) begin
            s = lo;
        end
        return s[SAT_MAX_BW-1:0];
    endfunction

endpackage

// File: rtl/psum_lane_sat_add.sv
// One psum lane: overwrite-or-saturating-accumulate on the write path,
// optional ReLU clamp on the drain path.
module psum_lane_sat_add
    import psum_accum_pkg::*;
#(
    parameter int unsigned psum_bw = 16
) (
    input  logic [psum_bw-1:0] i_mem,
    input  logic [psum_bw-1:0] i_in,
    input  logic               i_first,
    output logic [psum_bw-1:0] o_sum,
    input  logic [psum_bw-1:0] i_drain,
    input  logic               i_relu,
    output logic [psum_bw-1:0] o_drain
);

    logic signed [psum_bw-1:0]    w_mem_s;
    logic signed [psum_bw-1:0]    w_in_s;
    logic signed [SAT_MAX_BW-1:0] w_sum;
    logic                         w_unused_hi;

    assign w_mem_s = i_mem;
    assign w_in_s  = i_in;
    assign w_sum   = sat_add(SAT_MAX_BW'(w_mem_s), SAT_MAX_BW'(w_in_s), psum_bw);

    // Upper bits are pure sign extension after the clamp.
    assign w_unused_hi = ^w_sum[SAT_MAX_BW-1:psum_bw];

    assign o_sum   = i_first ? i_in : w_sum[psum_bw-1:0];
    assign o_drain = (i_relu && i_drain[psum_bw-1]) ? '0 : i_drain;

endmodule

// File: rtl/psum_accumulator.sv
// Partial-sum accumulation buffer: read-modify-write accumulation over
// npos positions x ntap taps, then valid/ready drain with optional ReLU.
module psum_accumulator
    import psum_accum_pkg::*;
#(
    parameter  int psum_bw = 16,
    parameter  int col     = 8,
    parameter  int depth   = 64,
    parameter  int tap_bw  = 4,
    localparam int ADDR_BW = $clog2(depth)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_BW:0]         cfg_npos,
    input  logic [tap_bw-1:0]        cfg_ntap,
    input  logic                     cfg_relu,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [psum_bw*col-1:0]   in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [psum_bw*col-1:0]   out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int                 ROW_W    = psum_bw * col;
    localparam logic [ADDR_BW:0]   NPOS_MAX = (ADDR_BW + 1)'(depth);
    localparam logic [ADDR_BW:0]   NPOS_ONE = (ADDR_BW + 1)'(1);
    localparam logic [ADDR_BW-1:0] ADDR_ONE = ADDR_BW'(1);
    localparam logic [tap_bw-1:0]  TAP_ONE  = tap_bw'(1);

    state_t             r_state;
    state_t             w_next;
    logic [ADDR_BW:0]   r_npos;
    logic [tap_bw-1:0]  r_ntap;
    logic [tap_bw-1:0]  r_tap;
    logic               r_relu;
    logic [ADDR_BW-1:0] r_pos;
    logic [ADDR_BW-1:0] r_idx;
    logic [ADDR_BW-1:0] r_a_addr;
    logic [ADDR_BW-1:0] w_rd_idx;
    logic               r_a_valid;
    logic               r_a_first;
    logic               r_out_valid;
    logic               r_done;
    logic               r_err;
    logic [ROW_W-1:0]   r_a_data;
    logic [ROW_W-1:0]   r_rd_data;
    logic [ROW_W-1:0]   r_out_data;
    logic [ROW_W-1:0]   w_b_row;
    logic [ROW_W-1:0]   w_drain_raw;
    logic [ROW_W-1:0]   w_drain_row;
    logic [ROW_W-1:0]   r_mem [depth];

    logic w_cfg_ok;
    logic w_in_hs;
    logic w_pos_last;
    logic w_tap_last;
    logic w_final;
    logic w_idx_last;
    logic w_fwd;

    assign w_cfg_ok   = (cfg_npos != '0) && (cfg_npos <= NPOS_MAX) && (cfg_ntap != '0);
    assign w_in_hs    = in_valid && (r_state == ACCUM);
    assign w_pos_last = ({1'b0, r_pos} == (r_npos - NPOS_ONE));
    assign w_tap_last = (r_tap == (r_ntap - TAP_ONE));
    assign w_final    = w_in_hs && w_pos_last && w_tap_last;
    assign w_idx_last = ({1'b0, r_idx} == (r_npos - NPOS_ONE));
    // Back-to-back beats to one row (npos==1): stage B's result beats the stale read.
    assign w_fwd      = r_a_valid && (r_a_addr == r_pos);
    // While a row is presented, prefetch the next one so a handshake reloads at once.
    assign w_rd_idx    = r_out_valid ? (r_idx + ADDR_ONE) : r_idx;
    assign w_drain_raw = r_mem[w_rd_idx];

    for (genvar g = 0; g < col; g++) begin : g_lane
        psum_lane_sat_add #(
            .psum_bw(psum_bw)
        ) u_lane (
            .i_mem  (r_rd_data[g*psum_bw +: psum_bw]),
            .i_in   (r_a_data[g*psum_bw +: psum_bw]),
            .i_first(r_a_first),
            .o_sum  (w_b_row[g*psum_bw +: psum_bw]),
            .i_drain(w_drain_raw[g*psum_bw +: psum_bw]),
            .i_relu (r_relu),
            .o_drain(w_drain_row[g*psum_bw +: psum_bw])
        );
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start && w_cfg_ok) w_next = ACCUM;
            ACCUM:   if (w_final) w_next = FLUSH;
            FLUSH:   if (r_a_valid) w_next = DRAIN;
            DRAIN:   if (r_out_valid && out_ready && w_idx_last) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_npos      <= '0;
            r_ntap      <= '0;
            r_relu      <= 1'b0;
            r_pos       <= '0;
            r_tap       <= '0;
            r_idx       <= '0;
            r_a_valid   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_a_valid <= w_in_hs;
            if ((r_state == IDLE) && start) begin
                if (w_cfg_ok) begin
                    r_npos <= cfg_npos;
                    r_ntap <= cfg_ntap;
                    r_relu <= cfg_relu;
                    r_pos  <= '0;
                    r_tap  <= '0;
                end else begin
                    r_err <= 1'b1;
                end
            end
            if (w_in_hs) begin
                if (w_pos_last) begin
                    r_pos <= '0;
                    r_tap <= r_tap + TAP_ONE;
                end else begin
                    r_pos <= r_pos + ADDR_ONE;
                end
            end
            if (r_state == FLUSH) begin
                r_idx <= '0;
            end
            if (r_state == DRAIN) begin
                if (!r_out_valid) begin
                    r_out_data  <= w_drain_row;
                    r_out_valid <= 1'b1;
                end else if (out_ready) begin
                    if (w_idx_last) begin
                        r_out_valid <= 1'b0;
                        r_done      <= 1'b1;
                    end else begin
                        r_idx      <= r_idx + ADDR_ONE;
                        r_out_data <= w_drain_row;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_hs) begin
            r_a_data  <= in_data;
            r_a_addr  <= r_pos;
            r_a_first <= (r_tap == '0);
            r_rd_data <= w_fwd ? w_b_row : r_mem[r_pos];
        end
        if (r_a_valid) begin
            r_mem[r_a_addr] <= w_b_row;
        end
    end

    assign in_ready  = (r_state == ACCUM);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = (r_state == DRAIN) && r_out_valid && w_idx_last;
    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: accumulate, saturate, forward, ReLU,
// stalled drain, config rejection and mid-run reset.
module tb_psum_accumulator;

    localparam int PB    = 16;
    localparam int COL   = 8;
    localparam int DEPTH = 64;
    localparam int TAPW  = 4;
    localparam int AB    = 6;
    localparam int RW    = PB * COL;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AB:0]   cfg_npos;
    logic [TAPW-1:0] cfg_ntap;
    logic          cfg_relu;
    logic          in_valid;
    logic          in_ready;
    logic [RW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          err;

    int n_total = 0;
    int n_bad   = 0;
    int mdl [DEPTH][COL];

    psum_accumulator #(
        .psum_bw(PB),
        .col    (COL),
        .depth  (DEPTH),
        .tap_bw (TAPW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .cfg_npos (cfg_npos),
        .cfg_ntap (cfg_ntap),
        .cfg_relu (cfg_relu),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic int clamp(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic logic [RW-1:0] alt(input int ev, input int od);
        logic [RW-1:0] r;
        for (int l = 0; l < COL; l++) r[l*PB +: PB] = (l % 2 == 0) ? ev[PB-1:0] : od[PB-1:0];
        return r;
    endfunction

    function automatic logic [RW-1:0] model_row(input int p, input bit relu);
        logic [RW-1:0] r;
        int v;
        for (int l = 0; l < COL; l++) begin
            v = mdl[p][l];
            if (relu && v < 0) v = 0;
            r[l*PB +: PB] = v[PB-1:0];
        end
        return r;
    endfunction

    function automatic int beat_val(input int mode, input int t, input int p, input int l);
        case (mode)
            0:       return 5;
            1:       return 3;
            2:       return 5000;
            3:       return (l == 0) ? t + 1 : 0;
            4:       return (l % 2 == 0) ? -7 : 7;
            default: return ((p * 37 + l * 11 + t * 53) % 400) - 200;
        endcase
    endfunction

    task automatic start_run(input int npos, input int ntap, input bit relu);
        @(negedge clk);
        cfg_npos = (AB + 1)'(npos);
        cfg_ntap = TAPW'(ntap);
        cfg_relu = relu;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("in_ready_rise", in_ready, 1);
    endtask

    // Called at a negedge; ends at the negedge after the last accepted beat.
    task automatic feed(input int npos, input int ntap, input int mode, input int limit);
        int n;
        int v;
        n = 0;
        for (int t = 0; t < ntap; t++) begin
            for (int p = 0; p < npos; p++) begin
                if (n < limit) begin
                    for (int l = 0; l < COL; l++) begin
                        v = beat_val(mode, t, p, l);
                        in_data[l*PB +: PB] = v[PB-1:0];
                        mdl[p][l] = (t == 0) ? v : clamp(mdl[p][l] + v);
                    end
                    in_valid = 1'b1;
                    n++;
                    @(negedge clk);
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input int npos, input bit rnd, input bit use_model,
                         input logic [RW-1:0] crow, input bit relu);
        int k;
        int budget;
        k = 0;
        budget = 0;
        while (k < npos && budget < 2000) begin
            @(negedge clk);
            budget++;
            if (out_valid) begin
                check("drain_data", out_data, use_model ? model_row(k, relu) : crow);
                check("drain_last", out_last, (k == npos - 1) ? 1 : 0);
                out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (out_ready) k++;
            end else begin
                out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
        if (k < npos) check("drain_timeout", k, npos);
        @(negedge clk);
        out_ready = 1'b0;
        check("done_pulse", done, 1);
        check("busy_fall", busy, 0);
        check("valid_after_done", out_valid, 0);
        @(negedge clk);
        check("done_clear", done, 0);
    endtask

    task automatic try_bad(input int npos, input int ntap);
        @(negedge clk);
        cfg_npos = (AB + 1)'(npos);
        cfg_ntap = TAPW'(ntap);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("err_pulse", err, 1);
        check("err_busy", busy, 0);
        check("err_in_ready", in_ready, 0);
        @(negedge clk);
        check("err_clear", err, 0);
        check("err_stay_idle", busy, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [RW-1:0] e;
        reset     = 1'b1;
        start     = 1'b0;
        cfg_npos  = '0;
        cfg_ntap  = '0;
        cfg_relu  = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {in_ready, out_valid, out_data, out_last, busy, done, err}, '0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_outputs", {in_ready, out_valid, out_last, busy, done, err}, '0);

        // npos=4, ntap=1, all 5s; also check flush/load latency
        start_run(4, 1, 0);
        feed(4, 1, 0, 999);
        @(negedge clk);
        check("flush_no_valid", out_valid, 0);
        check("flush_busy", busy, 1);
        check("flush_in_ready", in_ready, 0);
        @(negedge clk);
        check("e2_valid", out_valid, 1);
        drain(4, 0, 0, alt(5, 5), 0);

        // 9 taps of +3 -> 27
        start_run(4, 9, 0);
        feed(4, 9, 1, 999);
        drain(4, 0, 0, alt(27, 27), 0);

        // 9 taps of +5000 saturates at 32767
        start_run(4, 9, 0);
        feed(4, 9, 2, 999);
        drain(4, 0, 0, alt(32767, 32767), 0);

        // npos=1 back-to-back: 1+2+3+4+5 through forwarding
        start_run(1, 5, 0);
        feed(1, 5, 3, 999);
        e = '0;
        e[PB-1:0] = 16'd15;
        drain(1, 0, 0, e, 0);

        // alternating -7/+7 over 2 taps, with and without ReLU
        start_run(4, 2, 1);
        feed(4, 2, 4, 999);
        drain(4, 0, 0, alt(0, 14), 0);
        start_run(4, 2, 0);
        feed(4, 2, 4, 999);
        drain(4, 0, 0, alt(-14, 14), 0);

        // full depth, random out_ready stalls
        start_run(DEPTH, 3, 0);
        feed(DEPTH, 3, 5, 999);
        drain(DEPTH, 1, 1, '0, 0);

        // rejected configurations
        try_bad(0, 1);
        try_bad(DEPTH + 1, 1);
        try_bad(4, 0);

        // reset in the middle of ACCUM, then a clean run
        start_run(4, 3, 0);
        feed(4, 3, 0, 5);
        check("pre_rst_busy", busy, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_outputs", {in_ready, out_valid, out_data, out_last, busy, done, err}, '0);
        @(negedge clk);
        reset = 1'b0;
        start_run(4, 1, 0);
        feed(4, 1, 0, 999);
        drain(4, 0, 0, alt(5, 5), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
